// File: rtl/pipe_stage_elastic_if.sv
// Handshake bundle for one elastic pipeline stage: upstream beat in, downstream beat out.
// slave = the stage itself, master = the neighbouring logic that drives it.
interface pipe_stage_elastic_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage with 2-entry skid, 1-cycle latency, registered in_ready, full rate under out_ready=1.
// Backpressure fills the skid entry then drops in_ready; PIPE_STAGE_PERF_EN adds stall/bubble counters.
module pipe_stage_elastic #(
  parameter int WIDTH         = 32,
  parameter bit ZERO_ON_FLUSH = 1'b1,
  parameter int CNT_W         = 16
) (
  input  logic                  in_clk,
  input  logic                  in_rst,
  input  logic                  in_flush,
  pipe_stage_elastic_if.slave   bus,
  output logic [CNT_W-1:0]      out_stall_cnt,
  output logic [CNT_W-1:0]      out_bubble_cnt
);

  // State encoding is {skid_valid, main_valid}; 2'b10 is unreachable.
  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_ONE   = 2'b01,
    S_FULL  = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_dat_q, main_dat_d;
  logic [WIDTH-1:0] skid_dat_q, skid_dat_d;
  logic             in_rdy_q;
  logic             acc;
  logic             take;

  assign acc  = bus.in_valid & in_rdy_q & ~in_flush;
  assign take = state_q[0] & bus.out_ready;

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q    <= S_EMPTY;
      main_dat_q <= '0;
      skid_dat_q <= '0;
      in_rdy_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_dat_q <= main_dat_d;
      skid_dat_q <= skid_dat_d;
      in_rdy_q   <= ~state_d[1];
    end
  end

  always_comb begin
    state_d    = state_q;
    main_dat_d = main_dat_q;
    skid_dat_d = skid_dat_q;
    if (in_flush) begin
      state_d = S_EMPTY;
      if (ZERO_ON_FLUSH) begin
        main_dat_d = '0;
        skid_dat_d = '0;
      end
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (acc) begin
            main_dat_d = bus.in_data;
            state_d    = S_ONE;
          end
        end
        S_ONE: begin
          if (acc && take) begin
            main_dat_d = bus.in_data;
          end else if (acc) begin
            skid_dat_d = bus.in_data;
            state_d    = S_FULL;
          end else if (take) begin
            state_d    = S_EMPTY;
          end
        end
        S_FULL: begin
          if (take) begin
            main_dat_d = skid_dat_q;
            state_d    = S_ONE;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_comb begin
    bus.in_ready  = in_rdy_q;
    bus.out_valid = state_q[0];
    bus.out_data  = main_dat_q;
  end

`ifdef PIPE_STAGE_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] bubble_q;

  // Counters observe the handshake only, so flush leaves them running.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (state_q[0] && !bus.out_ready && !(&stall_q)) begin
        stall_q <= stall_q + CNT_ONE;
      end
      if (!state_q[0] && !(&bubble_q)) begin
        bubble_q <= bubble_q + CNT_ONE;
      end
    end
  end

  assign out_stall_cnt  = stall_q;
  assign out_bubble_cnt = bubble_q;
`else
  assign out_stall_cnt  = '0;
  assign out_bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench: two stages (ZERO_ON_FLUSH=1/CNT_W=16 and ZERO_ON_FLUSH=0/CNT_W=4) fed identical stimulus.
module tb_pipe_stage_elastic;

  logic        in_clk = 1'b0;
  logic        in_rst;
  logic        in_flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_data;
  logic [15:0] stall_a, bubble_a;
  logic [3:0]  stall_b, bubble_b;

  int vecs = 0;
  int errs = 0;

`ifdef PIPE_STAGE_PERF_EN
  localparam int EXP_STALL_A_MID = 9;
  localparam int EXP_STALL_A     = 20;
  localparam int EXP_STALL_B     = 15;
  localparam int EXP_BUBBLE      = 1;
`else
  localparam int EXP_STALL_A_MID = 0;
  localparam int EXP_STALL_A     = 0;
  localparam int EXP_STALL_B     = 0;
  localparam int EXP_BUBBLE      = 0;
`endif

  always #5 in_clk = ~in_clk;

  pipe_stage_elastic_if #(.WIDTH(32)) bus_a ();
  pipe_stage_elastic_if #(.WIDTH(32)) bus_b ();

  assign bus_a.in_valid  = in_valid;
  assign bus_a.in_data   = in_data;
  assign bus_a.out_ready = out_ready;
  assign bus_b.in_valid  = in_valid;
  assign bus_b.in_data   = in_data;
  assign bus_b.out_ready = out_ready;

  pipe_stage_elastic #(.WIDTH(32), .ZERO_ON_FLUSH(1'b1), .CNT_W(16)) dut_a (
    .in_clk        (in_clk),
    .in_rst        (in_rst),
    .in_flush      (in_flush),
    .bus           (bus_a),
    .out_stall_cnt (stall_a),
    .out_bubble_cnt(bubble_a)
  );

  pipe_stage_elastic #(.WIDTH(32), .ZERO_ON_FLUSH(1'b0), .CNT_W(4)) dut_b (
    .in_clk        (in_clk),
    .in_rst        (in_rst),
    .in_flush      (in_flush),
    .bus           (bus_b),
    .out_stall_cnt (stall_b),
    .out_bubble_cnt(bubble_b)
  );

  task automatic tick;
    @(posedge in_clk);
    #1;
  endtask

  task automatic do_reset;
    in_rst = 1'b1;
    #2;
    @(posedge in_clk);
    #1;
    in_rst = 1'b0;
  endtask

  task automatic test_reset;
    in_rst = 1'b1; in_flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #12;
    vecs++;
    if (bus_a.out_valid !== 1'b0 || bus_a.in_ready !== 1'b1 || bus_a.out_data !== 32'h0) begin
      errs++;
      $display("FAIL reset_a: valid=%b ready=%b data=%h, want 0 1 0", bus_a.out_valid, bus_a.in_ready, bus_a.out_data);
    end
    vecs++;
    if (bus_b.out_valid !== 1'b0 || bus_b.in_ready !== 1'b1 || stall_a !== 16'd0 || bubble_b !== 4'd0) begin
      errs++;
      $display("FAIL reset_b: valid=%b ready=%b stall_a=%0d bubble_b=%0d, want 0 1 0 0", bus_b.out_valid, bus_b.in_ready, stall_a, bubble_b);
    end
    @(posedge in_clk);
    #1;
    in_rst = 1'b0;
  endtask

  task automatic test_stream;
    logic [31:0] exp [4];
    exp = '{32'h11, 32'h22, 32'h33, 32'h44};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = exp[i];
      tick();
      vecs++;
      if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== exp[i] || bus_a.in_ready !== 1'b1 || bus_b.out_data !== exp[i]) begin
        errs++;
        $display("FAIL stream[%0d]: valid=%b data=%h/%h ready=%b, want 1 %h 1", i, bus_a.out_valid, bus_a.out_data, bus_b.out_data, bus_a.in_ready, exp[i]);
      end
    end
    in_valid = 1'b0;
    tick();
    vecs++;
    if (bus_a.out_valid !== 1'b0 || bus_b.out_valid !== 1'b0) begin
      errs++;
      $display("FAIL stream_drain: valid=%b/%b, want 0", bus_a.out_valid, bus_b.out_valid);
    end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA1;
    tick();
    vecs++;
    if (bus_a.out_data !== 32'hA1 || bus_a.in_ready !== 1'b1) begin
      errs++;
      $display("FAIL bp_first: data=%h ready=%b, want a1 1", bus_a.out_data, bus_a.in_ready);
    end
    in_data = 32'hA2;
    tick();
    vecs++;
    if (bus_a.out_data !== 32'hA1 || bus_a.in_ready !== 1'b0 || bus_b.in_ready !== 1'b0) begin
      errs++;
      $display("FAIL bp_full: data=%h ready=%b/%b, want a1 0", bus_a.out_data, bus_a.in_ready, bus_b.in_ready);
    end
    in_data = 32'hA3;
    tick();
    vecs++;
    if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== 32'hA1 || bus_a.in_ready !== 1'b0) begin
      errs++;
      $display("FAIL bp_hold: valid=%b data=%h ready=%b, want 1 a1 0", bus_a.out_valid, bus_a.out_data, bus_a.in_ready);
    end
    out_ready = 1'b1;
    tick();
    vecs++;
    if (bus_a.out_data !== 32'hA2 || bus_a.in_ready !== 1'b1 || bus_b.out_data !== 32'hA2) begin
      errs++;
      $display("FAIL bp_release1: data=%h/%h ready=%b, want a2 1", bus_a.out_data, bus_b.out_data, bus_a.in_ready);
    end
    tick();
    vecs++;
    if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== 32'hA3 || bus_b.out_data !== 32'hA3) begin
      errs++;
      $display("FAIL bp_release2: valid=%b data=%h/%h, want 1 a3", bus_a.out_valid, bus_a.out_data, bus_b.out_data);
    end
    in_valid = 1'b0;
    tick();
    vecs++;
    if (bus_a.out_valid !== 1'b0) begin
      errs++;
      $display("FAIL bp_drain: valid=%b, want 0", bus_a.out_valid);
    end
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hB1;
    tick();
    in_data = 32'hB2;
    tick();
    in_flush = 1'b1; in_data = 32'hB3;
    tick();
    in_flush = 1'b0; in_valid = 1'b0;
    vecs++;
    if (bus_a.out_valid !== 1'b0 || bus_a.in_ready !== 1'b1 || bus_a.out_data !== 32'h0) begin
      errs++;
      $display("FAIL flush_zero: valid=%b ready=%b data=%h, want 0 1 0", bus_a.out_valid, bus_a.in_ready, bus_a.out_data);
    end
    vecs++;
    if (bus_b.out_valid !== 1'b0 || bus_b.in_ready !== 1'b1 || bus_b.out_data !== 32'hB1) begin
      errs++;
      $display("FAIL flush_hold: valid=%b ready=%b data=%h, want 0 1 b1", bus_b.out_valid, bus_b.in_ready, bus_b.out_data);
    end
    out_ready = 1'b1;
    tick();
    vecs++;
    if (bus_a.out_valid !== 1'b0 || bus_b.out_valid !== 1'b0) begin
      errs++;
      $display("FAIL flush_no_ghost: valid=%b/%b, want 0", bus_a.out_valid, bus_b.out_valid);
    end
    in_valid = 1'b1; in_data = 32'hC0;
    tick();
    in_valid = 1'b0;
    vecs++;
    if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== 32'hC0 || bus_b.out_valid !== 1'b1 || bus_b.out_data !== 32'hC0) begin
      errs++;
      $display("FAIL flush_next: valid=%b/%b data=%h/%h, want 1 c0", bus_a.out_valid, bus_b.out_valid, bus_a.out_data, bus_b.out_data);
    end
    tick();
    vecs++;
    if (bus_a.out_valid !== 1'b0 || bus_b.out_valid !== 1'b0) begin
      errs++;
      $display("FAIL flush_drain: valid=%b/%b, want 0", bus_a.out_valid, bus_b.out_valid);
    end
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h71;
    tick();
    in_data = 32'h72;
    tick();
    #3;
    in_rst = 1'b1;
    #1;
    vecs++;
    if (bus_a.out_valid !== 1'b0 || bus_a.in_ready !== 1'b1 || bus_a.out_data !== 32'h0 || bus_b.in_ready !== 1'b1) begin
      errs++;
      $display("FAIL async_rst: valid=%b ready=%b/%b data=%h, want 0 1 0", bus_a.out_valid, bus_a.in_ready, bus_b.in_ready, bus_a.out_data);
    end
    vecs++;
    if (stall_a !== 16'd0 || bubble_a !== 16'd0 || stall_b !== 4'd0 || bubble_b !== 4'd0) begin
      errs++;
      $display("FAIL async_rst_cnt: %0d %0d %0d %0d, want 0", stall_a, bubble_a, stall_b, bubble_b);
    end
    in_valid = 1'b0;
    @(posedge in_clk);
    #1;
    in_rst = 1'b0;
  endtask

  task automatic test_perf;
    logic [3:0]  exp_b;
    logic [15:0] exp_a;
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h55;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    exp_a = 16'(EXP_STALL_A_MID);
    exp_b = 4'(EXP_STALL_A_MID);
    vecs++;
    if (stall_a !== exp_a || stall_b !== exp_b) begin
      errs++;
      $display("FAIL perf_mid: stall=%0d/%0d, want %0d", stall_a, stall_b, exp_a);
    end
    for (int i = 0; i < 11; i++) tick();
    exp_a = 16'(EXP_STALL_A);
    exp_b = 4'(EXP_STALL_B);
    vecs++;
    if (stall_a !== exp_a || stall_b !== exp_b) begin
      errs++;
      $display("FAIL perf_sat: stall=%0d/%0d, want %0d/%0d", stall_a, stall_b, exp_a, exp_b);
    end
    vecs++;
    if (bubble_a !== 16'(EXP_BUBBLE) || bubble_b !== 4'(EXP_BUBBLE)) begin
      errs++;
      $display("FAIL perf_bubble: bubble=%0d/%0d, want %0d", bubble_a, bubble_b, EXP_BUBBLE);
    end
    vecs++;
    if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== 32'h55 || bus_b.out_data !== 32'h55) begin
      errs++;
      $display("FAIL perf_stable: valid=%b data=%h/%h, want 1 55", bus_a.out_valid, bus_a.out_data, bus_b.out_data);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_perf();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
